register_file_sb: RTL and testbench



---
 rtl/register_file_sb.sv | 159 +++++++++++++++
 tb/tb_register_file_sb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_sb
//  Brief    : 2-read/1-write integer register file with optional write-to-read
//             bypass, per-register pending scoreboard and a sequential clear
//             engine that zeroes the array after reset or on request.
//  Revision : 1.0 - initial release
// ============================================================================
module register_file_sb #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 5,
    parameter int BYPASS      = 1,
    parameter int RESET_CLEAR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [XLEN-1:0]   rs1_o,
    output logic [XLEN-1:0]   rs2_o,
    output logic              rs1_pending_o,
    output logic              rs2_pending_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [XLEN-1:0]   wr_data_i,
    input  logic              wr_enable_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic              rsv_enable_i,
    output logic              busy_o
);

    localparam int              c_NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_X0       = '0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t c_RESET_STATE = (RESET_CLEAR != 0) ? ST_CLEAR : ST_IDLE;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_W-1:0]     r_cnt;
    logic [XLEN-1:0]       r_regs [c_NUM_REGS];
    logic [c_NUM_REGS-1:0] r_pending;

    logic w_busy;
    logic w_clear_start;
    logic w_wr_fire;
    logic w_rsv_fire;
    logic w_byp1;
    logic w_byp2;

    assign w_busy        = (r_state == ST_CLEAR);
    assign w_clear_start = (r_state == ST_IDLE) && clear_i;
    assign w_wr_fire     = wr_enable_i  && !w_busy && (wr_addr_i  != c_X0);
    assign w_rsv_fire    = rsv_enable_i && !w_busy && (rsv_addr_i != c_X0);
    assign busy_o        = w_busy;

    // Forwarding of the in-flight write to matching read ports (only when enabled).
    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_byp1 = w_wr_fire && (wr_addr_i == rs1_addr_i);
            assign w_byp2 = w_wr_fire && (wr_addr_i == rs2_addr_i);
        end else begin : g_no_bypass
            assign w_byp1 = 1'b0;
            assign w_byp2 = 1'b0;
        end
    endgenerate

    // Clear-engine state register; reset re-enters the configured start state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear-engine next state: a clear runs until the counter reaches the last register.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (clear_i) w_state_next = ST_CLEAR;
            ST_CLEAR: if (r_cnt == c_CNT_LAST) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Clear counter: restarts on reset or clear acceptance, walks the array while clearing.
    always_ff @(posedge clk) begin
        if (reset || w_clear_start) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Register array: the clear engine owns the write port while busy; reset leaves contents alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_busy) begin
                r_regs[r_cnt] <= '0;
            end else if (w_wr_fire) begin
                r_regs[wr_addr_i] <= wr_data_i;
            end
        end
    end

    // Scoreboard: writeback clears a bit, a same-cycle reservation then sets it again.
    always_ff @(posedge clk) begin
        if (reset || w_clear_start) begin
            r_pending <= '0;
        end else begin
            if (w_wr_fire) begin
                r_pending[wr_addr_i] <= 1'b0;
            end
            if (w_rsv_fire) begin
                r_pending[rsv_addr_i] <= 1'b1;
            end
        end
    end

    // Read port 1: busy forces a stall, x0 is hardwired, bypass beats the array.
    always_comb begin
        rs1_o         = r_regs[rs1_addr_i];
        rs1_pending_o = r_pending[rs1_addr_i];
        if (w_busy) begin
            rs1_o         = '0;
            rs1_pending_o = 1'b1;
        end else if (rs1_addr_i == c_X0) begin
            rs1_o         = '0;
            rs1_pending_o = 1'b0;
        end else if (w_byp1) begin
            rs1_o         = wr_data_i;
            rs1_pending_o = 1'b0;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rs2_o         = r_regs[rs2_addr_i];
        rs2_pending_o = r_pending[rs2_addr_i];
        if (w_busy) begin
            rs2_o         = '0;
            rs2_pending_o = 1'b1;
        end else if (rs2_addr_i == c_X0) begin
            rs2_o         = '0;
            rs2_pending_o = 1'b0;
        end else if (w_byp2) begin
            rs2_o         = wr_data_i;
            rs2_pending_o = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_sb
//  Brief    : Directed self-checking bench for register_file_sb. Three
//             instances share stimulus: A (bypass, reset-clear), B (no bypass,
//             reset-clear) and C (bypass, no reset-clear).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, wr_addr_i, rsv_addr_i;
    logic [31:0] wr_data_i;
    logic        wr_enable_i, rsv_enable_i;

    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b, rs1_c, rs2_c;
    logic        rs1p_a, rs2p_a, rs1p_b, rs2p_b, rs1p_c, rs2p_c;
    logic        busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    register_file_sb #(.XLEN(32), .ADDR_W(5), .BYPASS(1), .RESET_CLEAR(1)) dut_a (
        .clk(clk), .reset(reset), .clear_i(clear_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_o(rs1_a), .rs2_o(rs2_a), .rs1_pending_o(rs1p_a), .rs2_pending_o(rs2p_a),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_enable_i(wr_enable_i),
        .rsv_addr_i(rsv_addr_i), .rsv_enable_i(rsv_enable_i), .busy_o(busy_a)
    );

    register_file_sb #(.XLEN(32), .ADDR_W(5), .BYPASS(0), .RESET_CLEAR(1)) dut_b (
        .clk(clk), .reset(reset), .clear_i(clear_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_o(rs1_b), .rs2_o(rs2_b), .rs1_pending_o(rs1p_b), .rs2_pending_o(rs2p_b),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_enable_i(wr_enable_i),
        .rsv_addr_i(rsv_addr_i), .rsv_enable_i(rsv_enable_i), .busy_o(busy_b)
    );

    register_file_sb #(.XLEN(32), .ADDR_W(5), .BYPASS(1), .RESET_CLEAR(0)) dut_c (
        .clk(clk), .reset(reset), .clear_i(clear_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_o(rs1_c), .rs2_o(rs2_c), .rs1_pending_o(rs1p_c), .rs2_pending_o(rs2p_c),
        .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_enable_i(wr_enable_i),
        .rsv_addr_i(rsv_addr_i), .rsv_enable_i(rsv_enable_i), .busy_o(busy_c)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles busy stays high on instance A (bounded).
    task automatic count_busy(output int n);
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            step();
        end
    endtask

    // Read every register on both ports of A and B and expect zero, pending clear.
    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rs1_addr_i = 5'(i);
            rs2_addr_i = 5'(31 - i);
            #1;
            checks++;
            if (rs1_a !== 32'h0 || rs2_a !== 32'h0 || rs1_b !== 32'h0 || rs2_b !== 32'h0 ||
                rs1p_a !== 1'b0 || rs2p_a !== 1'b0 || rs1p_b !== 1'b0 || rs2p_b !== 1'b0) begin
                errors++;
                $display("FAIL %s x%0d: a=%h/%h b=%h/%h pend a=%b%b b=%b%b, required all 0",
                         tag, i, rs1_a, rs2_a, rs1_b, rs2_b, rs1p_a, rs2p_a, rs1p_b, rs2p_b);
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; clear_i = 1'b0;
        rs1_addr_i = 5'd3; rs2_addr_i = 5'd4;
        wr_addr_i = '0; wr_data_i = '0; wr_enable_i = 1'b0;
        rsv_addr_i = '0; rsv_enable_i = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1 || rs1_a !== 32'h0 || rs1p_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: busy a=%b b=%b rs1=%h pend=%b, required 1 1 0 1",
                     busy_a, busy_b, rs1_a, rs1p_a);
        end
        checks++;
        if (busy_c !== 1'b0 || rs1p_c !== 1'b0 || rs2p_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_noclear: busy_c=%b pend=%b%b, required 0 00",
                     busy_c, rs1p_c, rs2p_c);
        end
        count_busy(n);
        checks++;
        if (n != 32 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear_len: busy cycles=%0d busy_b=%b, required 32 0", n, busy_b);
        end
        check_all_zero("reset_contents");
    endtask

    task automatic test_bypass();
        rs1_addr_i = 5'd5;
        wr_addr_i = 5'd5; wr_data_i = 32'hDEADBEEF; wr_enable_i = 1'b1;
        #1;
        checks++;
        if (rs1_a !== 32'hDEADBEEF || rs1p_a !== 1'b0) begin
            errors++;
            $display("FAIL bypass_same_cycle: rs1=%h pend=%b, required deadbeef 0", rs1_a, rs1p_a);
        end
        checks++;
        if (rs1_b !== 32'h0) begin
            errors++;
            $display("FAIL nobypass_before_edge: rs1=%h, required 00000000", rs1_b);
        end
        step();
        wr_enable_i = 1'b0;
        #1;
        checks++;
        if (rs1_a !== 32'hDEADBEEF || rs1_b !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_after_edge: a=%h b=%h, required deadbeef", rs1_a, rs1_b);
        end
    endtask

    task automatic test_x0();
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
        wr_addr_i = 5'd0; wr_data_i = 32'h12345678; wr_enable_i = 1'b1;
        #1;
        checks++;
        if (rs1_a !== 32'h0 || rs2_a !== 32'h0) begin
            errors++;
            $display("FAIL x0_bypass: rs1=%h rs2=%h, required 0", rs1_a, rs2_a);
        end
        step();
        wr_enable_i = 1'b0;
        rsv_addr_i = 5'd0; rsv_enable_i = 1'b1;
        #1;
        checks++;
        if (rs1_a !== 32'h0 || rs2_a !== 32'h0 || rs1_b !== 32'h0 || rs2_b !== 32'h0) begin
            errors++;
            $display("FAIL x0_read: a=%h/%h b=%h/%h, required 0", rs1_a, rs2_a, rs1_b, rs2_b);
        end
        step();
        rsv_enable_i = 1'b0;
        #1;
        checks++;
        if (rs1p_a !== 1'b0 || rs2p_b !== 1'b0) begin
            errors++;
            $display("FAIL x0_reserve: pend a=%b b=%b, required 0", rs1p_a, rs2p_b);
        end
    endtask

    task automatic test_scoreboard();
        rs2_addr_i = 5'd7;
        rsv_addr_i = 5'd7; rsv_enable_i = 1'b1;
        #1;
        checks++;
        if (rs2p_a !== 1'b0) begin
            errors++;
            $display("FAIL rsv_before_edge: pend=%b, required 0", rs2p_a);
        end
        step();
        rsv_enable_i = 1'b0;
        #1;
        checks++;
        if (rs2p_a !== 1'b1 || rs2p_b !== 1'b1) begin
            errors++;
            $display("FAIL rsv_after_edge: pend a=%b b=%b, required 1", rs2p_a, rs2p_b);
        end
        wr_addr_i = 5'd7; wr_data_i = 32'hA5A5A5A5; wr_enable_i = 1'b1;
        #1;
        checks++;
        if (rs2p_a !== 1'b0 || rs2p_b !== 1'b1 || rs2_a !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wb_same_cycle: pend a=%b b=%b rs2=%h, required 0 1 a5a5a5a5",
                     rs2p_a, rs2p_b, rs2_a);
        end
        step();
        wr_enable_i = 1'b0;
        #1;
        checks++;
        if (rs2p_a !== 1'b0 || rs2p_b !== 1'b0 || rs2_b !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wb_release: pend a=%b b=%b rs2=%h, required 0 0 a5a5a5a5",
                     rs2p_a, rs2p_b, rs2_b);
        end
        wr_data_i = 32'h5A5A5A5A; wr_enable_i = 1'b1;
        rsv_enable_i = 1'b1;
        step();
        wr_enable_i = 1'b0; rsv_enable_i = 1'b0;
        #1;
        checks++;
        if (rs2_a !== 32'h5A5A5A5A || rs2_b !== 32'h5A5A5A5A || rs2p_a !== 1'b1 || rs2p_b !== 1'b1) begin
            errors++;
            $display("FAIL rsv_wins: rs2 a=%h b=%h pend a=%b b=%b, required 5a5a5a5a 1",
                     rs2_a, rs2_b, rs2p_a, rs2p_b);
        end
    endtask

    task automatic test_clear();
        int n;
        for (int i = 1; i < 32; i++) begin
            model[i] = $urandom;
            wr_addr_i = 5'(i); wr_data_i = model[i]; wr_enable_i = 1'b1;
            step();
        end
        wr_enable_i = 1'b0;
        rs1_addr_i = 5'd13; rs2_addr_i = 5'd31;
        #1;
        checks++;
        if (rs1_b !== model[13] || rs2_b !== model[31] || rs2p_b !== 1'b0) begin
            errors++;
            $display("FAIL fill_readback: x13=%h x31=%h pend=%b, required %h %h 0",
                     rs1_b, rs2_b, rs2p_b, model[13], model[31]);
        end
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        #1;
        checks++;
        if (rs1_a !== 32'h0 || rs1p_a !== 1'b1 || rs2_b !== 32'h0 || rs2p_b !== 1'b1) begin
            errors++;
            $display("FAIL busy_forcing: rs1=%h pend=%b rs2_b=%h pend_b=%b, required 0 1 0 1",
                     rs1_a, rs1p_a, rs2_b, rs2p_b);
        end
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            if (n == 10) clear_i = 1'b1;
            if (n == 20) begin
                wr_addr_i = 5'd3; wr_data_i = 32'hFFFF0000; wr_enable_i = 1'b1;
                rsv_addr_i = 5'd4; rsv_enable_i = 1'b1;
            end
            step();
            clear_i = 1'b0; wr_enable_i = 1'b0; rsv_enable_i = 1'b0;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL clear_len: busy cycles=%0d, required 32", n);
        end
        check_all_zero("clear_contents");
    endtask

    task automatic test_reset_mid_clear();
        int n;
        wr_addr_i = 5'd20; wr_data_i = 32'h11112222; wr_enable_i = 1'b1;
        step();
        wr_enable_i = 1'b0;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        for (int i = 0; i < 15; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        count_busy(n);
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL reset_mid_clear_len: busy cycles=%0d, required 32", n);
        end
        check_all_zero("restart_contents");
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
